zxuno_clken_gen: RTL

Parametrised successor to the free-running divider that derives clk14/clk7 from sysclk in the ZX-UNO top level. Generates all divided square-wave clocks from one counter, plus single-cycle clock-enable pulses on each rising and falling edge. Adds a CPU clock-enable with runtime turbo selection, switched glitch-free at period boundaries, and a contention hold. Sits in the top level between the DCM output (sysclk) and the machine core.

---
 rtl/zxuno_clk_pkg.sv | 16 +
 rtl/zxuno_turbo_sel.sv | 47 ++++
 rtl/zxuno_clken_gen.sv | 72 +++++++
 3 files changed

// File: rtl/zxuno_clk_pkg.sv
// Shared turbo encodings and CPU clock-enable bit selection for the ZX-UNO clock generator.
package zxuno_clk_pkg;

  localparam logic [1:0] TURBO_3M5 = 2'd0;
  localparam logic [1:0] TURBO_7M  = 2'd1;
  localparam logic [1:0] TURBO_14M = 2'd2;
  localparam logic [1:0] TURBO_28M = 2'd3;

  // Counter bit that drives the CPU enable; saturates at bit 0 for fast modes.
  function automatic int unsigned cpu_sel_idx(input int unsigned base, input logic [1:0] turbo);
    int unsigned t;
    t = 32'(turbo);
    return (t >= base) ? 32'd0 : (base - t);
  endfunction

endpackage

// File: rtl/zxuno_turbo_sel.sv
// Turbo request/active registers, period-boundary mode switch and held-gated CPU enable.
module zxuno_turbo_sel
  import zxuno_clk_pkg::*;
#(
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned CPU_BASE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       turbo_i,
  input  logic             boundary_i,
  input  logic [CNT_W-1:0] cen_pos_d_i,
  input  logic             cpu_hold_i,
  output logic             cpu_cen_o,
  output logic [1:0]       turbo_act_o
);

  localparam int unsigned SEL_W = (CNT_W > 2) ? $clog2(CNT_W) : 1;

  logic [1:0]       turbo_req_q;
  logic [1:0]       turbo_act_q, turbo_act_d;
  logic             cpu_cen_q, cpu_cen_d;
  logic [SEL_W-1:0] sel_c;

  // The mode taking effect at this edge selects the pulse formed at the same edge.
  always_comb begin
    turbo_act_d = boundary_i ? turbo_req_q : turbo_act_q;
    sel_c       = SEL_W'(cpu_sel_idx(CPU_BASE, turbo_act_d));
    cpu_cen_d   = cen_pos_d_i[sel_c] & ~cpu_hold_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      turbo_req_q <= TURBO_3M5;
      turbo_act_q <= TURBO_3M5;
      cpu_cen_q   <= 1'b0;
    end else begin
      turbo_req_q <= turbo_i;
      turbo_act_q <= turbo_act_d;
      cpu_cen_q   <= cpu_cen_d;
    end
  end

  assign cpu_cen_o   = cpu_cen_q;
  assign turbo_act_o = turbo_act_q;

endmodule

// File: rtl/zxuno_clken_gen.sv
// Master divider: square-wave clocks, edge-aligned enable pulses and a turbo-selectable CPU enable.
module zxuno_clken_gen
  import zxuno_clk_pkg::*;
#(
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned CPU_BASE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             resync_i,
  input  logic [1:0]       turbo_i,
  input  logic             cpu_hold_i,
  output logic [CNT_W-1:0] clk_div_o,
  output logic [CNT_W-1:0] cen_pos_o,
  output logic [CNT_W-1:0] cen_neg_o,
  output logic             cpu_cen_o,
  output logic [1:0]       turbo_act_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cen_pos_q, cen_pos_d;
  logic [CNT_W-1:0] cen_neg_q, cen_neg_d;
  logic [CNT_W-1:0] lo_mask, hi_mask;
  logic             boundary_c;

  // Pulses decode the next count so they line up with the clk_div edge they mark.
  always_comb begin
    cnt_d     = resync_i ? '0 : cnt_q + CNT_W'(1);
    cen_pos_d = '0;
    cen_neg_d = '0;
    lo_mask   = '0;
    hi_mask   = '0;
    for (int i = 0; i < CNT_W; i++) begin
      lo_mask      = (CNT_W'(1) << i) - CNT_W'(1);
      hi_mask      = (lo_mask << 1) | CNT_W'(1);
      cen_pos_d[i] = ~resync_i & cnt_d[i] & ~|(cnt_d & lo_mask);
      cen_neg_d[i] = ~resync_i & cnt_q[i] & ~|(cnt_d & hi_mask);
    end
    boundary_c = resync_i | (&cnt_q[CPU_BASE:0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      cen_pos_q <= '0;
      cen_neg_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      cen_pos_q <= cen_pos_d;
      cen_neg_q <= cen_neg_d;
    end
  end

  zxuno_turbo_sel #(
    .CNT_W    (CNT_W),
    .CPU_BASE (CPU_BASE)
  ) u_turbo_sel (
    .clk         (clk),
    .rst_n       (rst_n),
    .turbo_i     (turbo_i),
    .boundary_i  (boundary_c),
    .cen_pos_d_i (cen_pos_d),
    .cpu_hold_i  (cpu_hold_i),
    .cpu_cen_o   (cpu_cen_o),
    .turbo_act_o (turbo_act_o)
  );

  assign clk_div_o = cnt_q;
  assign cen_pos_o = cen_pos_q;
  assign cen_neg_o = cen_neg_q;

endmodule
